alu_issue_ctrl: RTL and testbench

- Multi-cycle issue controller that drives the 32-bit ALU: accepts one MIPS-style instruction word per handshake and decodes it to the ALU's 4-bit Control code.
- Selects the ALU A/B operands, samples Result/Zero, and produces the register write-back and branch decision.
- Sits between instruction fetch/register read and the write-back stage of the lab datapath.

---
 rtl/alu_issue_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//
// Multi-cycle issue controller for the lab datapath's 32-bit ALU. It accepts
// one MIPS-style instruction word per valid/ready handshake, decodes it to the
// ALU Control code, drives the ALU operands, samples Result/Zero, and reports
// the register write-back and branch decision with a one-cycle done pulse.
//
// Sequence: IDLE -> DECODE -> EXEC -> WB -> IDLE (one instruction per 4 cycles).
//
// Parameters:
//   PC_W           width of pc and branch_target
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   instr_valid    instruction word and operands are valid
//   instr_ready    controller can accept an instruction (IDLE only)
//   instr          instruction word
//   rs_val         value of register rs
//   rt_val         value of register rt
//   pc             address of the instruction
//   alu_a          ALU operand A
//   alu_b          ALU operand B
//   alu_ctrl       ALU Control code
//   alu_result     ALU Result (combinational from alu_a/alu_b/alu_ctrl)
//   alu_zero       ALU Zero flag
//   wb_en          one-cycle register write strobe
//   wb_addr        destination register
//   wb_data        write data (result sampled at the end of EXEC)
//   branch_taken   branch decision, valid only while done=1
//   branch_target  pc + 4 + (sext(imm) << 2), modulo 2^PC_W
//   illegal        undecodable instruction, valid while done=1
//   done           one-cycle completion pulse
//   issue_count    retired-instruction counter
//
// Optional feature (macro ISSUE_PERF_CNT_EN):
//   defined   - issue_count counts done pulses (legal or illegal), wrapping.
//   undefined - no counter register is built; issue_count is tied to 0.

module alu_issue_ctrl #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    input  logic [PC_W-1:0] pc,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [31:0]     alu_result,
    input  logic            alu_zero,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [31:0]     wb_data,
    output logic            branch_taken,
    output logic [PC_W-1:0] branch_target,
    output logic            illegal,
    output logic            done,
    output logic [31:0]     issue_count
);

    // ALU Control codes understood by the datapath ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // R-type funct codes
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    state_t state;

    // Instruction and operands captured at the handshake
    logic [31:0]     instr_q;
    logic [31:0]     rs_q;
    logic [31:0]     rt_q;
    logic [PC_W-1:0] pc_q;

    // Decoded properties carried from DECODE to the WB strobes
    logic wr_q;
    logic beq_q;
    logic bne_q;
    logic ill_q;

    // Instruction fields
    logic [5:0]  op_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  shamt_f;
    logic [5:0]  funct_f;
    logic [15:0] imm_f;
    logic [31:0] simm;
    logic [31:0] zimm;

    assign op_f    = instr_q[31:26];
    assign rt_f    = instr_q[20:16];
    assign rd_f    = instr_q[15:11];
    assign shamt_f = instr_q[10:6];
    assign funct_f = instr_q[5:0];
    assign imm_f   = instr_q[15:0];
    assign simm    = {{16{imm_f[15]}}, imm_f};
    assign zimm    = {16'h0000, imm_f};

    // The rs register number is resolved by the register-read stage; only
    // its value (rs_val) matters here.
    logic unused_rs_field;
    assign unused_rs_field = ^instr_q[25:21];

    // Branch offset kept signed so the size cast below sign-extends it to PC_W
    logic signed [17:0] br_off;
    assign br_off = {imm_f, 2'b00};

    // Combinational decode of the latched instruction; consumed in DECODE
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_waddr;
    logic        dec_write;
    logic        dec_beq;
    logic        dec_bne;
    logic        dec_illegal;

    always_comb begin
        dec_ctrl    = ALU_AND;
        dec_a       = rs_q;
        dec_b       = rt_q;
        dec_waddr   = 5'd0;
        dec_write   = 1'b0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        dec_illegal = 1'b0;

        case (op_f)
            OP_RTYPE: begin
                dec_waddr = rd_f;
                dec_write = 1'b1;
                case (funct_f)
                    FN_ADD: dec_ctrl = ALU_ADD;
                    FN_SUB: dec_ctrl = ALU_SUB;
                    FN_AND: dec_ctrl = ALU_AND;
                    FN_OR:  dec_ctrl = ALU_OR;
                    FN_SLT: dec_ctrl = ALU_SLT;
                    FN_SLL: begin
                        dec_ctrl = ALU_SLL;
                        dec_a    = rt_q;
                        dec_b    = {27'd0, shamt_f};
                    end
                    FN_SRL: begin
                        dec_ctrl = ALU_SRL;
                        dec_a    = rt_q;
                        dec_b    = {27'd0, shamt_f};
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_ctrl  = ALU_ADD;
                dec_b     = simm;
                dec_waddr = rt_f;
                dec_write = 1'b1;
            end
            OP_ANDI: begin
                dec_ctrl  = ALU_AND;
                dec_b     = zimm;
                dec_waddr = rt_f;
                dec_write = 1'b1;
            end
            OP_ORI: begin
                dec_ctrl  = ALU_OR;
                dec_b     = zimm;
                dec_waddr = rt_f;
                dec_write = 1'b1;
            end
            OP_SLTI: begin
                dec_ctrl  = ALU_SLT;
                dec_b     = simm;
                dec_waddr = rt_f;
                dec_write = 1'b1;
            end
            OP_BEQ: begin
                dec_ctrl = ALU_SUB;
                dec_beq  = 1'b1;
            end
            OP_BNE: begin
                dec_ctrl = ALU_SUB;
                dec_bne  = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        // Undecodable words drive a harmless AND of zeros and never write back
        if (dec_illegal) begin
            dec_ctrl  = ALU_AND;
            dec_a     = 32'd0;
            dec_b     = 32'd0;
            dec_waddr = 5'd0;
            dec_write = 1'b0;
        end
    end

    // Issue FSM with registered outputs. The strobes (done, wb_en,
    // branch_taken, illegal) default low every cycle so they only rise for
    // the single WB cycle; an asynchronous reset drops them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            instr_ready   <= 1'b1;
            instr_q       <= 32'd0;
            rs_q          <= 32'd0;
            rt_q          <= 32'd0;
            pc_q          <= '0;
            wr_q          <= 1'b0;
            beq_q         <= 1'b0;
            bne_q         <= 1'b0;
            ill_q         <= 1'b0;
            alu_a         <= 32'd0;
            alu_b         <= 32'd0;
            alu_ctrl      <= ALU_AND;
            wb_en         <= 1'b0;
            wb_addr       <= 5'd0;
            wb_data       <= 32'd0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            illegal       <= 1'b0;
            done          <= 1'b0;
        end else begin
            done         <= 1'b0;
            wb_en        <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;

            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        rs_q        <= rs_val;
                        rt_q        <= rt_val;
                        pc_q        <= pc;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    alu_ctrl      <= dec_ctrl;
                    alu_a         <= dec_a;
                    alu_b         <= dec_b;
                    wb_addr       <= dec_waddr;
                    wr_q          <= dec_write;
                    beq_q         <= dec_beq;
                    bne_q         <= dec_bne;
                    ill_q         <= dec_illegal;
                    branch_target <= pc_q + PC_W'(4) + PC_W'(br_off);
                    state         <= EXEC;
                end
                EXEC: begin
                    // Operands stay put; the ALU result is sampled here so
                    // wb_data never follows later changes on alu_result.
                    wb_data      <= alu_result;
                    branch_taken <= (beq_q && alu_zero) || (bne_q && !alu_zero);
                    wb_en        <= wr_q;
                    illegal      <= ill_q;
                    done         <= 1'b1;
                    state        <= WB;
                end
                WB: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    // Retired-instruction counter; wraps naturally at 2^32
    logic [31:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 32'd0;
        end else if (done) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign issue_count = count_q;
`else
    assign issue_count = 32'd0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//
// Scoreboard bench for alu_issue_ctrl. A simple ALU model closes the loop on
// alu_a/alu_b/alu_ctrl. Each issued instruction pushes the response predicted
// by refModel (computed directly from instruction semantics) into a queue; a
// monitor pops and compares on every done pulse. Directed cases are followed
// by a randomized stream. Honours ISSUE_PERF_CNT_EN the same way as the RTL.

module tb_alu_issue_ctrl;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [31:0]     rs_val;
    logic [31:0]     rt_val;
    logic [PC_W-1:0] pc;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [3:0]      alu_ctrl;
    logic [31:0]     alu_result;
    logic            alu_zero;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [31:0]     wb_data;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            illegal;
    logic            done;
    logic [31:0]     issue_count;

    alu_issue_ctrl #(.PC_W(PC_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .pc            (pc),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ctrl      (alu_ctrl),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .illegal       (illegal),
        .done          (done),
        .issue_count   (issue_count)
    );

    always #5 clk = ~clk;

    // Datapath ALU (unsigned compare for SLT)
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0100: alu_result = alu_a - alu_b;
            4'b0101: alu_result = alu_a << alu_b[4:0];
            4'b0110: alu_result = alu_a >> alu_b[4:0];
            4'b1000: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        taken;
        logic [31:0] target;
        logic        illegal;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        int          hs_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int done_seen = 0;

    logic [31:0] prev_a;
    logic [31:0] prev_b;
    logic [3:0]  prev_ctrl;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected response straight from instruction semantics
    function automatic exp_t refModel(input logic [31:0] iw, input logic [31:0] rs,
                                      input logic [31:0] rt, input logic [31:0] pcv);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] simm;
        logic [31:0] zimm;
        op   = iw[31:26];
        fn   = iw[5:0];
        sh   = iw[10:6];
        simm = {{16{iw[15]}}, iw[15:0]};
        zimm = {16'h0, iw[15:0]};
        e.wb_en   = 1'b0;
        e.wb_addr = 5'd0;
        e.wb_data = 32'd0;
        e.taken   = 1'b0;
        e.target  = pcv + 32'd4 + (simm << 2);
        e.illegal = 1'b0;
        e.ctrl    = 4'b0000;
        e.a       = rs;
        e.b       = rt;
        e.hs_cyc  = 0;
        if (op == 6'h00) begin
            e.wb_en   = 1'b1;
            e.wb_addr = iw[15:11];
            case (fn)
                6'h20: begin e.ctrl = 4'b0010; e.wb_data = rs + rt; end
                6'h22: begin e.ctrl = 4'b0100; e.wb_data = rs - rt; end
                6'h24: begin e.ctrl = 4'b0000; e.wb_data = rs & rt; end
                6'h25: begin e.ctrl = 4'b0001; e.wb_data = rs | rt; end
                6'h2a: begin e.ctrl = 4'b1000; e.wb_data = (rs < rt) ? 32'd1 : 32'd0; end
                6'h00: begin e.ctrl = 4'b0101; e.a = rt; e.b = {27'd0, sh}; e.wb_data = rt << sh; end
                6'h02: begin e.ctrl = 4'b0110; e.a = rt; e.b = {27'd0, sh}; e.wb_data = rt >> sh; end
                default: begin e.illegal = 1'b1; e.wb_en = 1'b0; end
            endcase
        end else begin
            e.wb_addr = iw[20:16];
            case (op)
                6'h08: begin e.ctrl = 4'b0010; e.b = simm; e.wb_en = 1'b1; e.wb_data = rs + simm; end
                6'h0c: begin e.ctrl = 4'b0000; e.b = zimm; e.wb_en = 1'b1; e.wb_data = rs & zimm; end
                6'h0d: begin e.ctrl = 4'b0001; e.b = zimm; e.wb_en = 1'b1; e.wb_data = rs | zimm; end
                6'h0a: begin e.ctrl = 4'b1000; e.b = simm; e.wb_en = 1'b1; e.wb_data = (rs < simm) ? 32'd1 : 32'd0; end
                6'h04: begin e.ctrl = 4'b0100; e.taken = (rs == rt); end
                6'h05: begin e.ctrl = 4'b0100; e.taken = (rs != rt); end
                default: e.illegal = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Monitor: compares every done pulse against the head of the scoreboard.
    // ALU drive is checked from the previous (EXEC) cycle's snapshot.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no pending instruction at cycle %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    // handshake cycle, DECODE, EXEC, then done in the 4th cycle
                    checkOutput("latency", cyc, mon_e.hs_cyc + 2);
                    checkOutput("instr_ready_in_wb", {31'd0, instr_ready}, 32'd0);
                    checkOutput("wb_en", {31'd0, wb_en}, {31'd0, mon_e.wb_en});
                    checkOutput("illegal", {31'd0, illegal}, {31'd0, mon_e.illegal});
                    checkOutput("branch_taken", {31'd0, branch_taken}, {31'd0, mon_e.taken});
                    checkOutput("branch_target", branch_target, mon_e.target);
                    checkOutput("alu_ctrl_exec", {28'd0, prev_ctrl}, {28'd0, mon_e.ctrl});
                    if (!mon_e.illegal) begin
                        checkOutput("alu_a_exec", prev_a, mon_e.a);
                        checkOutput("alu_b_exec", prev_b, mon_e.b);
                    end
                    if (mon_e.wb_en) begin
                        checkOutput("wb_addr", {27'd0, wb_addr}, {27'd0, mon_e.wb_addr});
                        checkOutput("wb_data", wb_data, mon_e.wb_data);
                    end
`ifdef ISSUE_PERF_CNT_EN
                    checkOutput("issue_count", issue_count, done_seen);
`else
                    checkOutput("issue_count", issue_count, 32'd0);
`endif
                    done_seen++;
                end
            end else begin
                checkOutput("strobe_without_done", {29'd0, wb_en, branch_taken, illegal}, 32'd0);
            end
        end
        prev_a    = alu_a;
        prev_b    = alu_b;
        prev_ctrl = alu_ctrl;
    end

    task automatic applyStimulus(input logic [31:0] iw, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [31:0] pcv);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while (!instr_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: got instr_ready=0 expected 1 within 50 cycles");
            return;
        end
        instr       = iw;
        rs_val      = rs;
        rt_val      = rt;
        pc          = pcv;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        e        = refModel(iw, rs, rt, pcv);
        e.hs_cyc = cyc;
        sb.push_back(e);
        instr_valid = 1'b0;
        instr       = $urandom;
        rs_val      = $urandom;
        rt_val      = $urandom;
        checkOutput("ready_low_after_handshake", {31'd0, instr_ready}, 32'd0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] randInstr();
        int         sel;
        logic [5:0] op;
        logic [5:0] fn;
        logic [31:0] iw;
        logic [5:0] rfn[7];
        logic [5:0] iop[6];
        rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};
        iop = '{6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h04, 6'h05};
        iw  = $urandom;
        sel = $urandom_range(0, 14);
        if (sel < 7) begin
            iw[31:26] = 6'h00;
            iw[5:0]   = rfn[sel];
        end else if (sel < 13) begin
            iw[31:26] = iop[sel - 7];
        end else if (sel == 13) begin
            do op = 6'($urandom_range(0, 63));
            while (op inside {6'h00, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h0d});
            iw[31:26] = op;
        end else begin
            do fn = 6'($urandom_range(0, 63));
            while (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02});
            iw[31:26] = 6'h00;
            iw[5:0]   = fn;
        end
        return iw;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rs;
        logic [31:0] rt;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        rs_val      = 32'd0;
        rt_val      = 32'd0;
        pc          = '0;
        $display("[TB] start");

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_wb_en", {31'd0, wb_en}, 32'd0);
        checkOutput("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_alu_b", alu_b, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        checkOutput("rst_flags", {30'd0, branch_taken, illegal}, 32'd0);
        checkOutput("rst_branch_target", branch_target, 32'd0);
        checkOutput("rst_issue_count", issue_count, 32'd0);
        rst = 1'b0;

        // Directed cases
        applyStimulus({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7, 32'h0);          // ADD r3,r1,r2
        applyStimulus({6'h00, 5'd0, 5'd2, 5'd4, 5'd31, 6'h00}, 32'h0, 32'h1, 32'h4);         // SLL r4,r2,31
        applyStimulus({6'h08, 5'd1, 5'd9, 16'hFFFF}, 32'h10, 32'h0, 32'h8);                  // ADDI r9
        applyStimulus({6'h0d, 5'd1, 5'd9, 16'hFFFF}, 32'h0, 32'h0, 32'hC);                   // ORI zext
        applyStimulus({6'h04, 5'd1, 5'd2, 16'hFFFF}, 32'h55, 32'h55, 32'h100);               // BEQ taken
        applyStimulus({6'h05, 5'd1, 5'd2, 16'hFFFF}, 32'h55, 32'h55, 32'h100);               // BNE not taken
        applyStimulus({6'h3f, 26'h123_4567}, 32'h1, 32'h2, 32'h200);                         // illegal opcode
        applyStimulus({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 32'd1, 32'd1, 32'h300);        // write to r0
        applyStimulus({6'h0a, 5'd1, 5'd9, 16'hFFFF}, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFC);   // SLTI unsigned, target wrap
        drain();
`ifdef ISSUE_PERF_CNT_EN
        checkOutput("count_after_directed", issue_count, done_seen);
`else
        checkOutput("count_after_directed", issue_count, 32'd0);
`endif

        // Reset in the middle of EXEC aborts the instruction
        applyStimulus({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("mid_exec_alu_ctrl", {28'd0, alu_ctrl}, 32'h2);
        rst = 1'b1;
        #1;
        checkOutput("mid_exec_rst_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("mid_exec_rst_strobes", {30'd0, done, wb_en}, 32'd0);
        sb.delete();
        done_seen = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("post_abort_quiet", {30'd0, done, wb_en}, 32'd0);
        end
        checkOutput("post_abort_count", issue_count, 32'd0);

        // Randomized stream
        for (int n = 0; n < 150; n++) begin
            rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            applyStimulus(randInstr(), rs, rt, $urandom);
        end
        drain();
`ifdef ISSUE_PERF_CNT_EN
        checkOutput("count_after_random", issue_count, done_seen);
`else
        checkOutput("count_after_random", issue_count, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
